// File: rtl/udp_tx_scheduler_pkg.sv
// udp_tx_scheduler shared definitions:
// header lengths, FSM encoding, index width helper.
package udp_tx_scheduler_pkg;

  localparam int UDP_HDR_LEN = 8;
  localparam int IP_HDR_LEN  = 20;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SEND,
    GAP
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/udp_tx_scheduler_rr_arbiter.sv
// Round-robin pick: req + ptr -> one-hot win, win_idx.
// Ports: req, ptr in; win, win_idx out (combinational).
module udp_tx_scheduler_rr_arbiter
  import udp_tx_scheduler_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IW     = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_CH-1:0] win,
  output logic [IW-1:0]     win_idx
);

  logic any;

  // Lowest requester overall is the wrap-around fallback;
  // the second pass overrides it with the lowest at/after ptr.
  always_comb begin
    win_idx = '0;
    any     = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_idx = IW'(i);
        any     = 1'b1;
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i] && (IW'(i) >= ptr)) begin
        win_idx = IW'(i);
      end
    end
  end

  assign win = any ? (NUM_CH'(1) << win_idx) : '0;

endmodule

// File: rtl/udp_tx_scheduler.sv
// Shares one MAC/UDP tx path among NUM_CH AXI-stream sources:
// ch_* in, m_axis_* out, latched UDP/IP header fields, grant, busy.
module udp_tx_scheduler
  import udp_tx_scheduler_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int IFG_CYCLES = 12
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [8*NUM_CH-1:0]  ch_tdata,
  input  logic [NUM_CH-1:0]    ch_tvalid,
  input  logic [NUM_CH-1:0]    ch_tlast,
  input  logic [NUM_CH-1:0]    ch_tuser,
  output logic [NUM_CH-1:0]    ch_tready,
  input  logic [16*NUM_CH-1:0] ch_src_port,
  input  logic [16*NUM_CH-1:0] ch_dst_port,
  input  logic [16*NUM_CH-1:0] ch_pay_len,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic                 m_axis_tready,
  output logic [15:0]          UDP_SrcPort,
  output logic [15:0]          UDP_DestPort,
  output logic [15:0]          UDP_TotLen,
  output logic [15:0]          IP_TotLen,
  output logic [NUM_CH-1:0]    grant,
  output logic                 busy
);

  localparam int IW = idx_w(NUM_CH);
  localparam logic [IW-1:0] LAST_CH = IW'(NUM_CH - 1);
  localparam logic [7:0] GAP_LAST =
    8'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [15:0] UDP_ADD = 16'(UDP_HDR_LEN);
  localparam logic [15:0] IP_ADD =
    16'(UDP_HDR_LEN + IP_HDR_LEN);

  state_t state, state_nx;

  logic [NUM_CH-1:0] req_q;
  logic [NUM_CH-1:0] win;
  logic [NUM_CH-1:0] grant_q;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     win_idx;
  logic [7:0]        gap_cnt;
  logic [15:0]       sel_src, sel_dst, sel_len;

  // Requests are frozen when leaving IDLE so a source that
  // drops tvalid before GRANT still wins its slot.
  udp_tx_scheduler_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_arb (
    .req     (req_q),
    .ptr     (rr_ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  always_comb begin
    sel_src = '0;
    sel_dst = '0;
    sel_len = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win[i]) begin
        sel_src = ch_src_port[16*i +: 16];
        sel_dst = ch_dst_port[16*i +: 16];
        sel_len = ch_pay_len[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_nx      = state;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    ch_tready     = '0;
    unique case (state)
      IDLE: begin
        if (|ch_tvalid) state_nx = GRANT;
      end
      GRANT: state_nx = SEND;
      SEND: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (grant_q[i]) begin
            m_axis_tdata  = ch_tdata[8*i +: 8];
            m_axis_tvalid = ch_tvalid[i];
            m_axis_tlast  = ch_tlast[i];
            m_axis_tuser  = ch_tuser[i];
            if (ch_tvalid[i] && ch_tlast[i] &&
                m_axis_tready) begin
              state_nx = (IFG_CYCLES > 0) ? GAP : IDLE;
            end
          end
        end
        ch_tready = grant_q & {NUM_CH{m_axis_tready}};
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req_q        <= '0;
      grant_q      <= '0;
      rr_ptr       <= '0;
      gap_cnt      <= '0;
      UDP_SrcPort  <= '0;
      UDP_DestPort <= '0;
      UDP_TotLen   <= '0;
      IP_TotLen    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) req_q <= ch_tvalid;
      if (state == GRANT) begin
        grant_q      <= win;
        rr_ptr       <= (win_idx == LAST_CH) ? '0
                                             : win_idx + 1'b1;
        UDP_SrcPort  <= sel_src;
        UDP_DestPort <= sel_dst;
        UDP_TotLen   <= sel_len + UDP_ADD;
        IP_TotLen    <= sel_len + IP_ADD;
      end
      if (state == SEND && state_nx != SEND) grant_q <= '0;
      gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : '0;
    end
  end

  assign grant = grant_q;
  assign busy  = (state != IDLE);

endmodule
